contour_reader: RTL and testbench
=================================

// Module: contour_reader
// PURPOSE
//  Consumer of the edge BRAM after the single-contour tracer finishes.
//  Raster-scans all WIDTH*HEIGHT words and emits the (x,y) of every word equal
//  to MATCH_CODE, i.e. the final traced contour, on a valid/ready stream.
//  Also reports pixel count and bounding box. Feeds the wing-shape/overlay stage.
// PARAMETERS
//  WIDTH       640     pixels per row
//  HEIGHT      480     rows
//  MATCH_CODE  3'b001  BRAM code of a kept contour pixel
//  READ_LAT    2       BRAM read latency in cycles: addr at N -> data at N+READ_LAT
//  FIFO_DEPTH  4       output FIFO entries; power of 2, >= READ_LAT+1
// PORTS
//  clk         in   1   system clock
//  rst_n       in   1   synchronous active-low reset
//  start       in   1   1-cycle pulse: begin scan; ignored while busy=1
//  bram_read   in   3   edge BRAM read data, READ_LAT cycles after edge_addr_read
//  edge_addr_read out 19 edge BRAM read address
//  pix_x       out  10  contour pixel column
//  pix_y       out  9   contour pixel row
//  pix_valid   out  1   pix_x/pix_y hold a pixel
//  pix_ready   in   1   downstream accepts when pix_valid & pix_ready
//  busy        out  1   scan or drain in progress
//  done        out  1   level; set when scan complete and FIFO empty; cleared by start
//  num_pixels  out  19  matches found in last/current scan
//  empty       out  1   with done: num_pixels == 0
//  min_x,max_x out  10  bounding box columns (0 when empty)
//  min_y,max_y out  9   bounding box rows (0 when empty)
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): state IDLE; all outputs 0; FIFO flushed;
//    in-flight reads discarded; min regs preset internally to max values.
//  - Reset mid-scan aborts immediately; no pixel emitted after reset cycle.
//  - States: IDLE -(start)-> SCAN -(last addr issued)-> DRAIN
//    -(pipe empty & FIFO empty)-> DONE -(start)-> SCAN. busy=1 in SCAN/DRAIN.
//  - On start: addr=0, x=y=0, num_pixels=0, done=0, empty=0, bbox reset.
//  - SCAN: issue one address per cycle when credit allows:
//    (fifo_count + in_flight) < FIFO_DEPTH; otherwise hold edge_addr_read.
//    Tag pipeline of READ_LAT stages carries {valid,x,y} alongside each read.
//    x wraps WIDTH-1 -> 0 with y+1; last address = WIDTH*HEIGHT-1 (307199).
//  - Returning tag valid & bram_read==MATCH_CODE: push {x,y} into FIFO,
//    num_pixels+1, update min/max same cycle. Other codes discarded.
//  - Credit rule guarantees FIFO never overflows; push and pop in same cycle
//    leave count unchanged. Stream order strictly raster order.
//  - pix_valid = FIFO not empty; pix_x/pix_y = FIFO head, stable while
//    pix_valid & ~pix_ready. First-word latency: READ_LAT+1 cycles from issue.
//  - Full-throughput (pix_ready=1): 1 address/cycle; scan ~WIDTH*HEIGHT+
//    READ_LAT+2 cycles.
//  - DONE: done=1; empty=(num_pixels==0); if empty bbox outputs forced 0.
//    Count/bbox hold until next start or reset. start in SCAN/DRAIN ignored.
//  - num_pixels saturates at 2^19-1 (unreachable with defaults).
// TESTING
//  1 All-zero BRAM, start -> no pix_valid, done=1, empty=1, num_pixels=0, bbox 0.
//  2 Match at (36,40),(100,40),(36,200) -> emitted in that order; count=3;
//    min_x=36 max_x=100 min_y=40 max_y=200.
//  3 Matches at addr 0 and 307199, codes 3'b111/3'b011 elsewhere -> only (0,0)
//    and (639,479) emitted; wrap and last address correct.
//  4 Full row y=10 =001, pix_ready toggles 1-of-3 cycles -> 640 pixels, no
//    loss/dup, FIFO never exceeds 4, outputs stable while stalled.
//  5 rst_n=0 for 1 cycle mid-scan, then start -> all outputs 0 after reset;
//    rescan yields full correct count; start during busy has no effect.
//  6 Back-to-back scans: second start after done -> done drops next cycle,
//    count/bbox recomputed from zero.

Source files
------------

// File: rtl/contour_reader.sv
// contour_reader
//   Raster-scans the edge BRAM (WIDTH*HEIGHT words, one address per cycle)
//   after the contour tracer has finished. It streams out the (x,y) of every
//   word equal to MATCH_CODE in raster order on a valid/ready interface, and
//   it reports the pixel count and the bounding box of those pixels.
//
//   Ports
//     clk, rst_n        clock, synchronous active-low reset
//     start             1-cycle pulse that begins a scan; ignored while busy
//     bram_read         BRAM data, READ_LAT cycles after edge_addr_read
//     edge_addr_read    BRAM read address
//     pix_x/pix_y       head of the output FIFO, qualified by pix_valid
//     pix_ready         downstream accept
//     busy              scan or drain in progress
//     done              level; scan finished and FIFO drained; cleared by start
//     num_pixels        matches found in the last or current scan
//     empty             with done: no match was found
//     min_/max_x/y      bounding box (0 while no pixel has been found)
//
//   state | meaning
//   IDLE  | after reset, waiting for start
//   SCAN  | issuing one BRAM address per cycle while credit allows
//   DRAIN | all addresses issued, waiting for reads and FIFO to empty
//   DONE  | results held, waiting for the next start
module contour_reader #(
  parameter int         WIDTH      = 640,
  parameter int         HEIGHT     = 480,
  parameter logic [2:0] MATCH_CODE = 3'b001,
  parameter int         READ_LAT   = 2,
  parameter int         FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  bram_read,
  output logic [18:0] edge_addr_read,
  output logic [9:0]  pix_x,
  output logic [8:0]  pix_y,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic        busy,
  output logic        done,
  output logic [18:0] num_pixels,
  output logic        empty,
  output logic [9:0]  min_x,
  output logic [9:0]  max_x,
  output logic [8:0]  min_y,
  output logic [8:0]  max_y
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;   // FIFO occupancy 0..FIFO_DEPTH
  localparam int UW = CW + 1;   // occupancy plus reads in flight
  localparam logic [18:0] LAST_ADDR = 19'(WIDTH * HEIGHT - 1);
  localparam logic [9:0]  X_LAST    = 10'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DRAIN, S_DONE} state_t;
  state_t state_q, state_d;

  logic [18:0] addr_q;
  logic [9:0]  x_q;
  logic [8:0]  y_q;

  logic        tag_v_q [READ_LAT];
  logic [9:0]  tag_x_q [READ_LAT];
  logic [8:0]  tag_y_q [READ_LAT];

  logic [18:0]   fifo_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;

  logic [18:0] num_q;
  logic [9:0]  min_x_q, max_x_q;
  logic [8:0]  min_y_q, max_y_q;

  logic [UW-1:0] in_flight;
  logic start_ok, credit_ok, issue, last_addr, push, pop;

  always_comb begin
    in_flight = '0;
    for (int i = 0; i < READ_LAT; i++) in_flight = in_flight + UW'(tag_v_q[i]);
  end

  // Counting every in-flight read (even one returning this cycle) against
  // the FIFO space means the FIFO can never be pushed when full.
  assign credit_ok = ({1'b0, count_q} + in_flight) < UW'(FIFO_DEPTH);
  assign start_ok  = start && (state_q == S_IDLE || state_q == S_DONE);
  assign issue     = (state_q == S_SCAN) && credit_ok;
  assign last_addr = (addr_q == LAST_ADDR);
  assign push      = tag_v_q[READ_LAT-1] && (bram_read == MATCH_CODE);
  assign pop       = (count_q != '0) && pix_ready;

  // FSM: state register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: if (start) state_d = S_SCAN;
      S_SCAN:         if (issue && last_addr) state_d = S_DRAIN;
      S_DRAIN:        if (in_flight == '0 && count_q == '0) state_d = S_DONE;
      default:        state_d = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy  = 1'b0;
    done  = 1'b0;
    empty = 1'b0;
    case (state_q)
      S_SCAN, S_DRAIN: busy = 1'b1;
      S_DONE: begin
        done  = 1'b1;
        empty = (num_q == '0);
      end
      default: ;
    endcase
  end

  // Address generator; the address holds on the last word after it is issued.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q <= '0;
      x_q    <= '0;
      y_q    <= '0;
    end else if (start_ok) begin
      addr_q <= '0;
      x_q    <= '0;
      y_q    <= '0;
    end else if (issue && !last_addr) begin
      addr_q <= addr_q + 19'd1;
      if (x_q == X_LAST) begin
        x_q <= '0;
        y_q <= y_q + 9'd1;
      end else begin
        x_q <= x_q + 10'd1;
      end
    end
  end

  // Tag pipeline: the last stage lines up with bram_read for the same address.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < READ_LAT; i++) tag_v_q[i] <= 1'b0;
    end else begin
      tag_v_q[0] <= issue;
      for (int i = 1; i < READ_LAT; i++) tag_v_q[i] <= tag_v_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    tag_x_q[0] <= x_q;
    tag_y_q[0] <= y_q;
    for (int i = 1; i < READ_LAT; i++) begin
      tag_x_q[i] <= tag_x_q[i-1];
      tag_y_q[i] <= tag_y_q[i-1];
    end
  end

  // Output FIFO
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= {tag_x_q[READ_LAT-1], tag_y_q[READ_LAT-1]};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: ;
      endcase
    end
  end

  // Count and bounding box; min registers start at their maximum value.
  always_ff @(posedge clk) begin
    if (!rst_n || start_ok) begin
      num_q   <= '0;
      min_x_q <= '1;
      max_x_q <= '0;
      min_y_q <= '1;
      max_y_q <= '0;
    end else if (push) begin
      if (num_q != '1) num_q <= num_q + 19'd1;
      if (tag_x_q[READ_LAT-1] < min_x_q) min_x_q <= tag_x_q[READ_LAT-1];
      if (tag_x_q[READ_LAT-1] > max_x_q) max_x_q <= tag_x_q[READ_LAT-1];
      if (tag_y_q[READ_LAT-1] < min_y_q) min_y_q <= tag_y_q[READ_LAT-1];
      if (tag_y_q[READ_LAT-1] > max_y_q) max_y_q <= tag_y_q[READ_LAT-1];
    end
  end

  assign edge_addr_read = addr_q;
  assign pix_valid      = (count_q != '0);
  assign pix_x          = pix_valid ? fifo_q[rd_ptr_q][18:9] : '0;
  assign pix_y          = pix_valid ? fifo_q[rd_ptr_q][8:0]  : '0;
  assign num_pixels     = num_q;
  // Until a pixel is found the min registers hold their preset, so hide them.
  assign min_x          = (num_q != '0) ? min_x_q : '0;
  assign max_x          = (num_q != '0) ? max_x_q : '0;
  assign min_y          = (num_q != '0) ? min_y_q : '0;
  assign max_y          = (num_q != '0) ? max_y_q : '0;

endmodule

// File: tb/tb_contour_reader.sv
// Bench for contour_reader. The image is shrunk to 40x24 so that several
// complete scans fit in a short run; the coordinates of the directed cases
// are scaled accordingly.
module tb_contour_reader;
  localparam int W   = 40;
  localparam int H   = 24;
  localparam int N   = W * H;
  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        pix_ready = 1'b0;
  logic [2:0]  bram_read;
  logic [18:0] edge_addr_read;
  logic [9:0]  pix_x, min_x, max_x;
  logic [8:0]  pix_y, min_y, max_y;
  logic        pix_valid, busy, done, empty;
  logic [18:0] num_pixels;

  contour_reader #(
    .WIDTH(W), .HEIGHT(H), .MATCH_CODE(3'b001), .READ_LAT(LAT), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bram_read(bram_read),
    .edge_addr_read(edge_addr_read), .pix_x(pix_x), .pix_y(pix_y),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .busy(busy), .done(done),
    .num_pixels(num_pixels), .empty(empty), .min_x(min_x), .max_x(max_x),
    .min_y(min_y), .max_y(max_y)
  );

  always #5 clk = ~clk;

  // BRAM with a two-cycle read pipeline
  logic [2:0] mem [N];
  logic [2:0] rd_pipe [LAT];
  always @(posedge clk) begin
    rd_pipe[0] <= (int'(edge_addr_read) < N) ? mem[edge_addr_read] : 3'b000;
    for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign bram_read = rd_pipe[LAT-1];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference model: matches listed in raster order, plus count and bbox.
  logic [18:0] exp_q [$];
  int exp_cnt, e_minx, e_maxx, e_miny, e_maxy;

  task automatic build_model();
    exp_q.delete();
    exp_cnt = 0;
    e_minx = W; e_maxx = -1; e_miny = H; e_maxy = -1;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        if (mem[y*W + x] == 3'b001) begin
          exp_q.push_back({10'(x), 9'(y)});
          exp_cnt++;
          if (x < e_minx) e_minx = x;
          if (x > e_maxx) e_maxx = x;
          if (y < e_miny) e_miny = y;
          if (y > e_maxy) e_maxy = y;
        end
    if (exp_cnt == 0) begin
      e_minx = 0; e_maxx = 0; e_miny = 0; e_maxy = 0;
    end
  endtask

  task automatic fill(input logic [2:0] v);
    for (int i = 0; i < N; i++) mem[i] = v;
  endtask

  task automatic set_px(input int x, input int y, input logic [2:0] v);
    mem[y*W + x] = v;
  endtask

  // Downstream ready: mode 0 always ready, mode 1 ready one cycle in three
  int ready_mode = 0;
  int rcyc = 0;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      rcyc++;
      pix_ready = (ready_mode == 0) ? 1'b1 : ((rcyc % 3) == 0);
    end
  end

  // Per-cycle compare against the model
  bit          stalled_prev = 0;
  bit          busy_prev = 0;
  logic [9:0]  px_prev = '0;
  logic [8:0]  py_prev = '0;
  logic [18:0] addr_prev = '0;
  int          max_addr_seen = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stalled_prev = 0;
        busy_prev    = 0;
      end else begin
        if (pix_valid) begin
          if (stalled_prev) begin
            chk("hold_x", pix_x, px_prev);
            chk("hold_y", pix_y, py_prev);
          end
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pix: got (%0d,%0d) expected none", pix_x, pix_y);
          end else begin
            chk("pix_x", pix_x, exp_q[0][18:9]);
            chk("pix_y", pix_y, exp_q[0][8:0]);
            if (pix_ready) void'(exp_q.pop_front());
          end
        end else if (stalled_prev) begin
          chk("valid_hold", pix_valid, 1);
        end
        if (busy) begin
          if (busy_prev)
            chk("addr_step", (edge_addr_read == addr_prev) ||
                             (edge_addr_read == addr_prev + 19'd1), 1);
          if (int'(edge_addr_read) > max_addr_seen) max_addr_seen = int'(edge_addr_read);
        end
        stalled_prev = pix_valid && !pix_ready;
        px_prev      = pix_x;
        py_prev      = pix_y;
        busy_prev    = busy;
        addr_prev    = edge_addr_read;
      end
    end
  end

  task automatic pulse_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic finish_scan(input string nm);
    for (int i = 0; i < 4*N + 200; i++) begin
      @(negedge clk);
      if (done) break;
    end
    chk({nm, "_done"}, done, 1);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_count"}, num_pixels, exp_cnt);
    chk({nm, "_empty"}, empty, exp_cnt == 0);
    chk({nm, "_min_x"}, min_x, e_minx);
    chk({nm, "_max_x"}, max_x, e_maxx);
    chk({nm, "_min_y"}, min_y, e_miny);
    chk({nm, "_max_y"}, max_y, e_maxy);
    chk({nm, "_undelivered"}, exp_q.size(), 0);
    chk({nm, "_pix_valid"}, pix_valid, 0);
    chk({nm, "_last_addr"}, max_addr_seen, N - 1);
  endtask

  task automatic run_scan(input string nm);
    build_model();
    max_addr_seen = 0;
    pulse_start();
    finish_scan(nm);
  endtask

  task automatic check_all_zero(input string nm);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_done"}, done, 0);
    chk({nm, "_empty"}, empty, 0);
    chk({nm, "_valid"}, pix_valid, 0);
    chk({nm, "_num"}, num_pixels, 0);
    chk({nm, "_addr"}, edge_addr_read, 0);
    chk({nm, "_px"}, pix_x, 0);
    chk({nm, "_py"}, pix_y, 0);
    chk({nm, "_bbox"}, {min_x, max_x, min_y, max_y}, 0);
  endtask

  initial begin
    fill(3'b000);
    for (int i = 0; i < LAT; i++) rd_pipe[i] = 3'b000;
    ready_mode = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check_all_zero("reset");

    // 1: nothing matches
    run_scan("t1");
    chk("t1_lit_empty", empty, 1);
    chk("t1_lit_num", num_pixels, 0);

    // 2: three scattered matches
    fill(3'b000);
    set_px(6, 4, 3'b001);
    set_px(30, 4, 3'b001);
    set_px(6, 20, 3'b001);
    run_scan("t2");
    chk("t2_lit_num", num_pixels, 3);
    chk("t2_lit_min_x", min_x, 6);
    chk("t2_lit_max_x", max_x, 30);
    chk("t2_lit_min_y", min_y, 4);
    chk("t2_lit_max_y", max_y, 20);

    // 3: first and last word only, other non-zero codes elsewhere
    for (int i = 0; i < N; i++) mem[i] = (i % 2 == 1) ? 3'b111 : 3'b011;
    mem[0]     = 3'b001;
    mem[N - 1] = 3'b001;
    run_scan("t3");
    chk("t3_lit_num", num_pixels, 2);
    chk("t3_lit_max_x", max_x, W - 1);
    chk("t3_lit_max_y", max_y, H - 1);

    // 6: back-to-back scan after done restarts count and bbox from zero
    build_model();
    max_addr_seen = 0;
    pulse_start();
    chk("t6_done_drop", done, 0);
    chk("t6_num_clear", num_pixels, 0);
    finish_scan("t6");
    chk("t6_lit_num", num_pixels, 2);

    // 4: full row under back-pressure
    fill(3'b000);
    for (int x = 0; x < W; x++) set_px(x, 10, 3'b001);
    ready_mode = 1;
    run_scan("t4");
    chk("t4_lit_num", num_pixels, W);
    chk("t4_lit_min_y", min_y, 10);
    chk("t4_lit_max_y", max_y, 10);

    // 5: reset in the middle of the row, then a full rescan with a stray start
    build_model();
    pulse_start();
    repeat (10*W + 20) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    exp_q.delete();
    check_all_zero("t5_rst");
    repeat (6) @(posedge clk);
    #1;
    chk("t5_quiet_valid", pix_valid, 0);
    chk("t5_quiet_busy", busy, 0);
    build_model();
    max_addr_seen = 0;
    pulse_start();
    repeat (200) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk("t5_start_ignored", busy, 1);
    finish_scan("t5");
    chk("t5_lit_num", num_pixels, W);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
